lane_serializer: RTL and testbench

- Parallel-to-serial counterpart of the per-lane capture register banks.
- Accepts one LANES-wide word per valid/ready handshake and holds each lane in its own generate-built register.
- Emits enabled lanes one per cycle on a narrow valid/ready stream, lowest lane first.
- Sits between wide datapath capture logic and narrow downstream consumers such as debug/trace muxes.

---
 rtl/lane_ser_pkg.sv | 18 +
 rtl/lane_next_find.sv | 37 +++
 rtl/lane_serializer.sv | 138 +++++++++++++
 tb/tb_lane_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_ser_pkg.sv
// Shared types and sizing helpers for the lane serializer.
package lane_ser_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    localparam int unsigned DefLanes = 4;
    localparam int unsigned DefLaneW = 8;
    localparam int unsigned DefDropW = 8;

    // Lane index width; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_next_find.sv
// Finds the lowest set mask bit at/above a start index and whether it is the top set bit.
module lane_next_find
    import lane_ser_pkg::*;
#(
    parameter int unsigned Lanes = DefLanes,
    parameter int unsigned IdxW  = idx_w(Lanes)
) (
    input  logic [Lanes-1:0] mask_i,
    input  logic [IdxW-1:0]  start_i,
    input  logic             incl_i,
    output logic             found_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             last_o
);

    // Descending scan so the lowest qualifying lane wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = Lanes - 1; k >= 0; k--) begin
            if (mask_i[k] && ((k > int'(start_i)) || (incl_i && (k == int'(start_i))))) begin
                found_o = 1'b1;
                idx_o   = IdxW'(k);
            end
        end
    end

    always_comb begin
        last_o = found_o;
        for (int k = 0; k < Lanes; k++) begin
            if (mask_i[k] && (k > int'(idx_o))) begin
                last_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lane_serializer.sv
// Captures one wide word per handshake and streams its enabled lanes out, lowest first.
module lane_serializer
    import lane_ser_pkg::*;
#(
    parameter int unsigned Lanes = DefLanes,
    parameter int unsigned LaneW = DefLaneW,
    parameter int unsigned DropW = DefDropW
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [Lanes*LaneW-1:0]   in_data_i,
    input  logic [Lanes-1:0]         in_mask_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [LaneW-1:0]         out_data_o,
    output logic [idx_w(Lanes)-1:0]  out_lane_o,
    output logic                     out_last_o,
    output logic [DropW-1:0]         drop_cnt_o
);

    localparam int unsigned IdxW = idx_w(Lanes);

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        cur_q, cur_d;
    logic                   last_q, last_d;
    logic [Lanes-1:0]       mask_q, mask_d;
    logic [DropW-1:0]       drop_q, drop_d;
    logic [Lanes*LaneW-1:0] lanes_flat;

    logic            out_valid, xfer, accept;
    logic            first_found, first_last, nxt_found, nxt_last;
    logic [IdxW-1:0] first_idx, nxt_idx;

    lane_next_find #(
        .Lanes (Lanes),
        .IdxW  (IdxW)
    ) u_first (
        .mask_i  (in_mask_i),
        .start_i ('0),
        .incl_i  (1'b1),
        .found_o (first_found),
        .idx_o   (first_idx),
        .last_o  (first_last)
    );

    lane_next_find #(
        .Lanes (Lanes),
        .IdxW  (IdxW)
    ) u_next (
        .mask_i  (mask_q),
        .start_i (cur_q),
        .incl_i  (1'b0),
        .found_o (nxt_found),
        .idx_o   (nxt_idx),
        .last_o  (nxt_last)
    );

    assign out_valid  = (state_q == StShift);
    assign xfer       = out_valid && out_ready_i;
    assign in_ready_o = rst_ni && ((state_q == StIdle) || (xfer && last_q));
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        mask_d  = mask_q;
        drop_d  = drop_q;
        // A new word can only be accepted when nothing remains of the held one.
        if (accept) begin
            mask_d = in_mask_i;
            if (first_found) begin
                state_d = StShift;
                cur_d   = first_idx;
                last_d  = first_last;
            end else begin
                state_d = StIdle;
                if (drop_q != {DropW{1'b1}}) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end else if (xfer) begin
            if (nxt_found) begin
                cur_d  = nxt_idx;
                last_d = nxt_last;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cur_q   <= '0;
            last_q  <= 1'b0;
            mask_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            drop_q  <= drop_d;
        end
    end

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
        logic [LaneW-1:0] lane_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lane_q <= '0;
            end else if (accept) begin
                lane_q <= in_data_i[k*LaneW +: LaneW];
            end
        end

        assign lanes_flat[k*LaneW +: LaneW] = lane_q;
    end

    always_comb begin
        out_data_o = '0;
        for (int k = 0; k < Lanes; k++) begin
            if (out_valid && (cur_q == IdxW'(k))) begin
                out_data_o = lanes_flat[k*LaneW +: LaneW];
            end
        end
    end

    assign out_valid_o = out_valid;
    assign out_lane_o  = out_valid ? cur_q : '0;
    assign out_last_o  = out_valid && last_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer with a queue-based reference model checked every cycle.
module tb_lane_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic [7:0]  drop_cnt;

    lane_serializer #(
        .Lanes (4),
        .LaneW (8),
        .DropW (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_mask_i   (in_mask),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_lane_o  (out_lane),
        .out_last_o  (out_last),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lane;
        int data;
        bit last;
    } exp_t;

    typedef struct {
        int cyc;
        int lane;
        int data;
        bit last;
        bit rdy;
    } beat_t;

    exp_t  q[$];
    beat_t log_q[$];
    int    mdrop;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mrdy;
    bit    exp_v;
    bit    exp_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a held word is just the list of its enabled lanes still to send.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mdrop = 0;
        end else begin
            mrdy = (q.size() == 0) || ((q.size() == 1) && out_ready);
            if ((q.size() != 0) && out_ready) void'(q.pop_front());
            if (in_valid && mrdy) begin
                if (in_mask == 4'b0000) begin
                    if (mdrop < 255) mdrop++;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        if (in_mask[k]) begin
                            q.push_back('{lane: k, data: int'((in_data >> (8 * k)) & 32'hFF),
                                          last: ((in_mask >> (k + 1)) == 0)});
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_drop_cnt", 32'(drop_cnt), 0);
            chk("rst_out_data", 32'(out_data), 0);
            chk("rst_out_lane", 32'(out_lane), 0);
            chk("rst_out_last", 32'(out_last), 0);
        end else begin
            exp_v = (q.size() != 0);
            exp_r = (q.size() == 0) || ((q.size() == 1) && out_ready);
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            chk("in_ready", 32'(in_ready), 32'(exp_r));
            chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
            if (exp_v && out_valid) begin
                chk("out_lane", 32'(out_lane), 32'(q[0].lane));
                chk("out_data", 32'(out_data), 32'(q[0].data));
                chk("out_last", 32'(out_last), 32'(q[0].last));
            end
            if (out_valid && out_ready) begin
                log_q.push_back('{cyc: cyc, lane: int'(out_lane), data: int'(out_data),
                                  last: out_last, rdy: in_ready});
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] m, output int acc);
        acc = -1;
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        for (int t = 0; t < 50 && acc < 0; t++) begin
            @(negedge clk);
            if (in_ready) acc = cyc + 1;
        end
        if (acc < 0) chk("send_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string name, input int i, input int c, input int lane,
                            input int data, input bit last);
        if (i < log_q.size()) begin
            chk({name, "_cyc"}, 32'(log_q[i].cyc), 32'(c));
            chk({name, "_lane"}, 32'(log_q[i].lane), 32'(lane));
            chk({name, "_data"}, 32'(log_q[i].data), 32'(data));
            chk({name, "_last"}, 32'(log_q[i].last), 32'(last));
        end
    endtask

    int acc;
    int acc2;

    initial begin
        in_valid  = 1'b1;
        in_mask   = 4'b0000;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;

        // Reset with in_valid high, then release.
        repeat (3) begin
            @(negedge clk);
            chk("t1_in_ready_rst", 32'(in_ready), 0);
            chk("t1_out_valid_rst", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_in_ready_rel", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        settle();

        // Reset in the middle of a word.
        send(32'hDDCC_BBAA, 4'b1111, acc);
        repeat (3) @(negedge clk);
        chk("t1_mid_lane", 32'(out_lane), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_mid_out_valid", 32'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_after_out_valid", 32'(out_valid), 0);
        end
        settle();

        // Full-mask word under continuous out_ready.
        log_q.delete();
        send(32'hDDCC_BBAA, 4'b1111, acc);
        repeat (6) @(negedge clk);
        chk("t2_beats", 32'(log_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk_beat("t2", i, acc + i, i, 'hAA + 'h11 * i, i == 3);
            if (i < log_q.size()) chk("t2_in_ready", 32'(log_q[i].rdy), 32'(i == 3));
        end
        settle();

        // Sparse mask skips disabled lanes without bubbles.
        log_q.delete();
        send(32'h4433_2211, 4'b1010, acc);
        repeat (4) @(negedge clk);
        chk("t3_beats", 32'(log_q.size()), 2);
        chk_beat("t3_b0", 0, acc, 1, 'h22, 1'b0);
        chk_beat("t3_b1", 1, acc + 1, 3, 'h44, 1'b1);
        settle();

        // Backpressure while lane 1 is presented.
        log_q.delete();
        send(32'hDDCC_BBAA, 4'b1111, acc);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(out_valid), 1);
            chk("t4_hold_lane", 32'(out_lane), 1);
            chk("t4_hold_data", 32'(out_data), 'hBB);
            chk("t4_hold_last", 32'(out_last), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("t4_beats", 32'(log_q.size()), 4);
        chk_beat("t4_b0", 0, acc, 0, 'hAA, 1'b0);
        chk_beat("t4_b1", 1, acc + 4, 1, 'hBB, 1'b0);
        chk_beat("t4_b2", 2, acc + 5, 2, 'hCC, 1'b0);
        chk_beat("t4_b3", 3, acc + 6, 3, 'hDD, 1'b1);
        settle();

        // Back-to-back words with no idle cycle between them.
        log_q.delete();
        send(32'hDDCC_BBAA, 4'b1111, acc);
        send(32'h8877_6655, 4'b0001, acc2);
        chk("t5_accept_cycle", 32'(acc2), 32'(acc + 4));
        repeat (4) @(negedge clk);
        chk("t5_beats", 32'(log_q.size()), 5);
        chk_beat("t5_b3", 3, acc + 3, 3, 'hDD, 1'b1);
        chk_beat("t5_b4", 4, acc + 4, 0, 'h55, 1'b1);
        settle();

        // Zero-mask words only bump the saturating drop counter.
        log_q.delete();
        in_mask  = 4'b0000;
        in_data  = 32'h1234_5678;
        in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t6_drop_sat", 32'(drop_cnt), 255);
        chk("t6_no_beats", 32'(log_q.size()), 0);
        chk("t6_in_ready", 32'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
